// File: rtl/latency_meter_if.sv
// ---------------------------------------------------------------------------
// latency_meter_if
//   Result read-out port of latency_meter: a valid/ready stream of
//   {rd_timeout, rd_data} samples. The head word is shown first-word-fall-
//   through and is popped on rd_valid & rd_ready.
//
//   rd_valid    master->slave  result FIFO non-empty; rd_data/rd_timeout valid
//   rd_ready    slave->master  consumer takes the head entry this cycle
//   rd_data     master->slave  latency in clk cycles (CNT_WIDTH bits)
//   rd_timeout  master->slave  head entry is a timeout sample
// ---------------------------------------------------------------------------
interface latency_meter_if #(
  parameter int CNT_WIDTH = 32
) ();
  logic                 rd_valid;
  logic                 rd_ready;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_timeout;

  modport master (output rd_valid, output rd_data, output rd_timeout, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_timeout, output rd_ready);
endinterface

// File: rtl/latency_meter.sv
// ---------------------------------------------------------------------------
// latency_meter
//   Times each rising edge of the stimulus pulse (sent to the board) to the
//   board's GPIO response rising edge, in clk cycles. Each result (or a
//   timeout sample) is queued in a small FIFO and read out over the
//   latency_meter_if valid/ready port.
//
//   Ports
//     clk        in   system clock (100 MHz)
//     reset_n    in   synchronous, active-low reset
//     stim       in   stimulus level (asynchronous)
//     resp       in   response level (asynchronous)
//     arm_en     in   1 = accept new stimulus edges
//     busy       out  measurement in progress (state != IDLE)
//     rd         if   master side of latency_meter_if (result stream)
//     drop_cnt   out  samples lost to a full FIFO, saturates at 255
//     min_lat    out  smallest non-timeout latency since reset
//     max_lat    out  largest non-timeout latency since reset
//
//   Build option
//     LAT_MINMAX_EN  defined: min_lat/max_lat track every non-timeout sample
//                    (dropped ones included). Undefined: min_lat is all-ones
//                    and max_lat is zero, with no compare logic.
// ---------------------------------------------------------------------------
module latency_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 100000000,
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stim,
  input  logic                 resp,
  input  logic                 arm_en,
  output logic                 busy,
  latency_meter_if.master      rd,
  output logic [7:0]           drop_cnt,
  output logic [CNT_WIDTH-1:0] min_lat,
  output logic [CNT_WIDTH-1:0] max_lat
);

  localparam int                   DEPTH       = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]     FULL_LVL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    HOLDOFF   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers. Both paths have identical depth, so the
  // synchronizer delay cancels out of the measured difference.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] stim_sync, resp_sync;
  logic                   stim_d, resp_d;
  logic                   stim_s, resp_s;
  logic                   stim_rise, resp_rise;

  assign stim_s = stim_sync[SYNC_STAGES-1];
  assign resp_s = resp_sync[SYNC_STAGES-1];

  // NOTE: sequential state always uses non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stim_sync <= '0;
      resp_sync <= '0;
      stim_d    <= 1'b0;
      resp_d    <= 1'b0;
    end else begin
      stim_sync <= {stim_sync[SYNC_STAGES-2:0], stim};
      resp_sync <= {resp_sync[SYNC_STAGES-2:0], resp};
      stim_d    <= stim_s;
      resp_d    <= resp_s;
    end
  end

  assign stim_rise = stim_s & ~stim_d;
  assign resp_rise = resp_s & ~resp_d;

  // -------------------------------------------------------------------------
  // Measurement FSM. The result is registered into push_req/push_* and
  // written to the FIFO in the following cycle.
  // -------------------------------------------------------------------------
  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic                 push_req;
  logic                 push_to;
  logic [CNT_WIDTH-1:0] push_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      push_req  <= 1'b0;
      push_to   <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (stim_rise && arm_en) begin
            busy <= 1'b1;
            if (resp_rise) begin
              // Both edges landed in the same cycle: zero latency.
              push_req  <= 1'b1;
              push_to   <= 1'b0;
              push_data <= '0;
              state     <= HOLDOFF;
            end else begin
              count <= CNT_ONE;
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          // arm_en is deliberately not looked at: a started measurement
          // always runs to completion.
          if (resp_rise) begin
            push_req  <= 1'b1;
            push_to   <= 1'b0;
            push_data <= count;
            state     <= HOLDOFF;
          end else if (count == TIMEOUT_VAL) begin
            push_req  <= 1'b1;
            push_to   <= 1'b1;
            push_data <= TIMEOUT_VAL;
            state     <= HOLDOFF;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        HOLDOFF: begin
          // Re-arm only once the stimulus has returned low, so one long
          // pulse cannot start a second measurement.
          if (!stim_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO, first-word-fall-through. A push into a full FIFO is still
  // accepted when the head is popped in the same cycle.
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     fill;
  logic                 empty, full;
  logic                 do_pop, do_push, do_drop;
  logic [CNT_WIDTH:0]   head;

  assign empty   = (fill == '0);
  assign full    = (fill == FULL_LVL);
  assign do_pop  = ~empty & rd.rd_ready;
  assign do_push = push_req & (~full | do_pop);
  assign do_drop = push_req & full & ~do_pop;

  // NOTE: the storage array has no reset; validity is carried by fill and
  // the pointers, and leaving it unreset lets it map onto plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_to, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (do_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Outputs read as zero while empty so nothing stale from the unreset
  // array is ever visible.
  assign head          = mem[rd_ptr];
  assign rd.rd_valid   = ~empty;
  assign rd.rd_data    = empty ? '0 : head[CNT_WIDTH-1:0];
  assign rd.rd_timeout = ~empty & head[CNT_WIDTH];

  // -------------------------------------------------------------------------
  // Min/max tracking, taken from the push request so dropped samples count.
  // -------------------------------------------------------------------------
`ifdef LAT_MINMAX_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      min_lat <= '1;
      max_lat <= '0;
    end else if (push_req && !push_to) begin
      if (push_data < min_lat) min_lat <= push_data;
      if (push_data > max_lat) max_lat <= push_data;
    end
  end
`else
  assign min_lat = '1;
  assign max_lat = '0;
`endif

endmodule

// File: tb/tb_latency_meter.sv
module tb_latency_meter;

  localparam int TO = 1000;

`ifdef LAT_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stim, resp, arm_en;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [31:0] min_lat, max_lat;

  int checks = 0;
  int errors = 0;

  latency_meter_if #(.CNT_WIDTH(32)) rd_if ();

  latency_meter #(
    .CNT_WIDTH  (32),
    .TIMEOUT    (TO),
    .FIFO_AW    (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .stim     (stim),
    .resp     (resp),
    .arm_en   (arm_en),
    .busy     (busy),
    .rd       (rd_if.master),
    .drop_cnt (drop_cnt),
    .min_lat  (min_lat),
    .max_lat  (max_lat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          d;         // stim-to-resp delay in clk cycles
    bit          no_resp;   // never raise resp (timeout)
    bit          arm;       // arm_en when stim rises
    bit          drop_arm;  // drop arm_en while waiting for resp
    bit          exp_entry;
    logic [31:0] exp_data;
    bit          exp_to;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stim = 1'b0;
    resp = 1'b0;
    arm_en = 1'b1;
    rd_if.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic measure(input int d, input bit no_resp, input bit arm, input bit drop_arm);
    @(posedge clk);
    #1 arm_en = arm;
    stim = 1'b1;
    if (no_resp) begin
      repeat (TO + 20) @(posedge clk);
    end else begin
      repeat (d) @(posedge clk);
      #1 resp = 1'b1;
      if (drop_arm) arm_en = 1'b0;
      repeat (12) @(posedge clk);
    end
    @(negedge clk);
    check("busy_while_stim_high", busy, arm);
    @(posedge clk);
    #1 stim = 1'b0;
    resp = 1'b0;
    arm_en = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("busy_after_stim_low", busy, 0);
  endtask

  task automatic pop_check(input logic [31:0] exp_data, input bit exp_to, input string name);
    @(negedge clk);
    check({name, "_valid"}, rd_if.rd_valid, 1);
    check({name, "_data"}, rd_if.rd_data, exp_data);
    check({name, "_timeout"}, rd_if.rd_timeout, exp_to);
    rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{d: 50, no_resp: 0, arm: 1, drop_arm: 0, exp_entry: 1, exp_data: 50, exp_to: 0};
    vecs[1] = '{d: 0,  no_resp: 1, arm: 1, drop_arm: 0, exp_entry: 1, exp_data: TO, exp_to: 1};
    vecs[2] = '{d: 0,  no_resp: 0, arm: 1, drop_arm: 0, exp_entry: 1, exp_data: 0,  exp_to: 0};
    vecs[3] = '{d: 1,  no_resp: 0, arm: 1, drop_arm: 0, exp_entry: 1, exp_data: 1,  exp_to: 0};
    vecs[4] = '{d: 7,  no_resp: 0, arm: 0, drop_arm: 0, exp_entry: 0, exp_data: 0,  exp_to: 0};
    vecs[5] = '{d: 12, no_resp: 0, arm: 1, drop_arm: 1, exp_entry: 1, exp_data: 12, exp_to: 0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_if.rd_valid, 0);
    check("rst_rd_data", rd_if.rd_data, 0);
    check("rst_rd_timeout", rd_if.rd_timeout, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_min_lat", min_lat, 32'hFFFF_FFFF);
    check("rst_max_lat", max_lat, 0);

    // Directed vector table: one measurement each, then read back
    for (int i = 0; i < 6; i++) begin
      measure(vecs[i].d, vecs[i].no_resp, vecs[i].arm, vecs[i].drop_arm);
      if (vecs[i].exp_entry) begin
        pop_check(vecs[i].exp_data, vecs[i].exp_to, $sformatf("vec%0d", i));
      end
      @(negedge clk);
      check($sformatf("vec%0d_empty", i), rd_if.rd_valid, 0);
    end
    check("tbl_min_lat", min_lat, MM ? 32'd0 : 32'hFFFF_FFFF);
    check("tbl_max_lat", max_lat, MM ? 32'd50 : 32'd0);

    // Min/max: 50, 20, 80 then a timeout
    do_reset();
    measure(50, 0, 1, 0);
    measure(20, 0, 1, 0);
    measure(80, 0, 1, 0);
    pop_check(50, 0, "mm0");
    pop_check(20, 0, "mm1");
    pop_check(80, 0, "mm2");
    check("mm_min_lat", min_lat, MM ? 32'd20 : 32'hFFFF_FFFF);
    check("mm_max_lat", max_lat, MM ? 32'd80 : 32'd0);
    measure(0, 1, 1, 0);
    pop_check(TO, 1, "mm_to");
    check("mm_min_after_to", min_lat, MM ? 32'd20 : 32'hFFFF_FFFF);
    check("mm_max_after_to", max_lat, MM ? 32'd80 : 32'd0);

    // Reset in the middle of WAIT_RESP, then resp rises
    @(posedge clk);
    #1 stim = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    do_reset();
    #1 resp = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_valid", rd_if.rd_valid, 0);
    #1 resp = 1'b0;
    repeat (4) @(posedge clk);

    // Overflow: 17 samples into a 16-deep FIFO with no reads
    for (int i = 0; i < 17; i++) measure(2 + i, 0, 1, 0);
    @(negedge clk);
    check("ovf_drop_cnt", drop_cnt, 1);
    check("ovf_min_lat", min_lat, MM ? 32'd2 : 32'hFFFF_FFFF);
    check("ovf_max_lat", max_lat, MM ? 32'd18 : 32'd0);

    // Push into the full FIFO in the same cycle as a pop: must be accepted.
    // resp set at P_d+1 -> synced at P_d+2, push registered at P_d+3,
    // written at P_d+4, where rd_ready is held for exactly that edge.
    @(posedge clk);
    #1 stim = 1'b1;
    repeat (30) @(posedge clk);
    #1 resp = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_if.rd_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1 stim = 1'b0;
    resp = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("full_pop_push_drop_cnt", drop_cnt, 1);
    for (int i = 1; i < 16; i++) pop_check(2 + i, 0, $sformatf("ovf%0d", i));
    pop_check(30, 0, "ovf_last");
    @(negedge clk);
    check("ovf_drained", rd_if.rd_valid, 0);

    // Pop while empty: no effect
    rd_if.rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd_if.rd_ready = 1'b0;
    @(negedge clk);
    check("pop_empty_valid", rd_if.rd_valid, 0);
    check("pop_empty_drop_cnt", drop_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
